// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared 7-segment definitions: bus bit positions, active-low
//               a..g digit patterns and the pattern-to-digit decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Bit positions on the 8-bit {a,b,c,d,e,f,g,dp} segment bus
    localparam int unsigned c_bus_a  = 7;
    localparam int unsigned c_bus_g  = 1;
    localparam int unsigned c_bus_dp = 0;

    // Active-low a..g patterns, a in bit 6
    localparam logic [6:0] c_pat_0     = 7'b0000001;
    localparam logic [6:0] c_pat_1     = 7'b1001111;
    localparam logic [6:0] c_pat_2     = 7'b0010010;
    localparam logic [6:0] c_pat_3     = 7'b0000110;
    localparam logic [6:0] c_pat_4     = 7'b1001100;
    localparam logic [6:0] c_pat_5     = 7'b0100100;
    localparam logic [6:0] c_pat_6a    = 7'b1100000;
    localparam logic [6:0] c_pat_6b    = 7'b0100000;
    localparam logic [6:0] c_pat_7a    = 7'b0001101;
    localparam logic [6:0] c_pat_7b    = 7'b0001111;
    localparam logic [6:0] c_pat_8     = 7'b0000000;
    localparam logic [6:0] c_pat_9     = 7'b0000100;
    localparam logic [6:0] c_pat_blank = 7'b1111111;

    typedef struct packed {
        logic       hit;
        logic [3:0] value;
    } seg7_dec_t;

    function automatic seg7_dec_t seg7_to_digit(input logic [6:0] pat);
        seg7_dec_t r;
        r.hit   = 1'b1;
        r.value = 4'd0;
        case (pat)
            c_pat_0:            r.value = 4'd0;
            c_pat_1:            r.value = 4'd1;
            c_pat_2:            r.value = 4'd2;
            c_pat_3:            r.value = 4'd3;
            c_pat_4:            r.value = 4'd4;
            c_pat_5:            r.value = 4'd5;
            c_pat_6a, c_pat_6b: r.value = 4'd6;
            c_pat_7a, c_pat_7b: r.value = 4'd7;
            c_pat_8:            r.value = 4'd8;
            c_pat_9:            r.value = 4'd9;
            default:            r.hit   = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_slot_status.sv
`default_nettype none
// ============================================================================
// Module      : seg7_slot_status
// Description : Status registers and staleness age counter for one slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_slot_status
    import seg7_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic       wr_hit,
    input  logic       wr_blank,
    input  logic [3:0] wr_value,
    input  logic       wr_dp,
    output logic [3:0] digit,
    output logic       valid,
    output logic       blank,
    output logic       err,
    output logic       dp
);

    localparam int unsigned c_age_w = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_age_w-1:0] c_age_last   = c_age_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_age_w-1:0] c_age_expire = c_age_w'(TIMEOUT_CYCLES - 2);

    logic [3:0]         digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               blank_q, blank_d;
    logic               err_q,   err_d;
    logic               dp_q,    dp_d;
    logic [c_age_w-1:0] age_q,   age_d;

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        blank_d = blank_q;
        err_d   = err_q;
        dp_d    = dp_q;
        age_d   = age_q;
        if (we) begin
            age_d   = '0;
            valid_d = wr_hit;
            blank_d = !wr_hit && wr_blank;
            err_d   = !wr_hit && !wr_blank;
            dp_d    = wr_dp;
            if (wr_hit) begin
                digit_d = wr_value;
            end
        end else begin
            // Age saturates at TIMEOUT-1; valid drops on the edge that reaches it
            if (age_q != c_age_last) begin
                age_d = age_q + 1'b1;
            end
            if (age_q == c_age_expire) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= 4'd0;
            valid_q <= 1'b0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
            dp_q    <= 1'b0;
            age_q   <= '0;
        end else begin
            digit_q <= digit_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            dp_q    <= dp_d;
            age_q   <= age_d;
        end
    end

    assign digit = digit_q;
    assign valid = valid_q;
    assign blank = blank_q;
    assign err   = err_q;
    assign dp    = dp_q;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Samples a multiplexed active-low segment/anode bus, filters it
//               for stability and reconstructs the digit shown on each slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] digit,
    output logic [3:0]  valid,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic [3:0]  dp,
    output logic        upd,
    output logic [1:0]  upd_slot
);

    localparam logic [7:0] c_cnt_max  = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_cnt_last = 8'(STABLE_CYCLES - 1);

    // Bus word layout: {seg_n[7:0], an_n[3:0]}
    logic [11:0] sync1_q, sync1_d;
    logic [11:0] sync2_q, sync2_d;
    logic [11:0] held_q,  held_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        upd_q,   upd_d;
    logic [1:0]  upd_slot_q, upd_slot_d;

    logic        w_capture;
    logic [3:0]  w_sel;
    logic        w_onehot;
    logic [1:0]  w_slot;
    logic        w_write;
    logic [3:0]  w_we;
    logic [6:0]  w_pat;
    seg7_dec_t   w_dec;
    logic        w_is_blank;
    logic        w_dp;

    always_comb begin
        sync1_d = {seg_n, an_n};
        sync2_d = sync1_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        if (sync2_q != held_q) begin
            held_d = sync2_q;
            cnt_d  = 8'd0;
        end else if (cnt_q < c_cnt_max) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires once per stable episode, on the STABLE-1 -> STABLE count step
    assign w_capture = (sync2_q == held_q) && (cnt_q == c_cnt_last);

    assign w_sel    = ~held_q[3:0];
    assign w_onehot = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);

    always_comb begin
        w_slot = 2'd0;
        case (w_sel)
            4'b0010: w_slot = 2'd1;
            4'b0100: w_slot = 2'd2;
            4'b1000: w_slot = 2'd3;
            default: w_slot = 2'd0;
        endcase
    end

    assign w_write    = w_capture && w_onehot;
    assign w_we       = w_write ? w_sel : 4'd0;
    assign w_pat      = held_q[c_bus_a+4:c_bus_g+4];
    assign w_dec      = seg7_to_digit(w_pat);
    assign w_is_blank = (w_pat == c_pat_blank);
    assign w_dp       = ~held_q[c_bus_dp+4];

    always_comb begin
        upd_d      = w_write;
        upd_slot_d = w_write ? w_slot : upd_slot_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            held_q     <= '1;
            cnt_q      <= 8'd0;
            upd_q      <= 1'b0;
            upd_slot_q <= 2'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            upd_q      <= upd_d;
            upd_slot_q <= upd_slot_d;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_slot
            seg7_slot_status #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_slot (
                .clk      (clk),
                .reset    (reset),
                .we       (w_we[i]),
                .wr_hit   (w_dec.hit),
                .wr_blank (w_is_blank),
                .wr_value (w_dec.value),
                .wr_dp    (w_dp),
                .digit    (digit[4*i +: 4]),
                .valid    (valid[i]),
                .blank    (blank[i]),
                .err      (err[i]),
                .dp       (dp[i])
            );
        end
    endgenerate

    assign upd      = upd_q;
    assign upd_slot = upd_slot_q;

endmodule
`default_nettype wire
